proc_control_fsm: RTL and testbench

- Multi-cycle control unit for the 16-bit bus processor: eight 16-bit registers R0..R7, a 9-bit IR, registers A and G, an adder/subtractor, and synchronous memory.
- R7 is the PC.
- Sequences fetch and execute by driving every register-enable, bus-select, PC-increment, address-load and memory-write strobe.
- Starts on Run; reports instruction completion with Done.

---
 rtl/proc_pkg.sv | 39 +++
 rtl/dec3to8.sv | 11 +
 rtl/proc_control_fsm.sv | 164 ++++++++++++++++
 tb/tb_proc_control_fsm.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared constants and types for the bus-processor control unit.
// Opcodes, state encoding and the program-counter register index.
package proc_pkg;

  localparam int unsigned PC_IDX = 7;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_F_ADDR = 3'd1;
  localparam logic [2:0] ST_F_WAIT = 3'd2;
  localparam logic [2:0] ST_F_LOAD = 3'd3;
  localparam logic [2:0] ST_E1     = 3'd4;
  localparam logic [2:0] ST_E2     = 3'd5;
  localparam logic [2:0] ST_E3     = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    F_ADDR = ST_F_ADDR,
    F_WAIT = ST_F_WAIT,
    F_LOAD = ST_F_LOAD,
    E1     = ST_E1,
    E2     = ST_E2,
    E3     = ST_E3
  } state_t;

  // Instructions that finish in E1 (mv, mvnz, reserved NOP).
  function automatic logic is_short_op(input logic [2:0] op);
    return (op == OP_MV) || (op == OP_MVNZ) || (op == OP_NOP);
  endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
// Purely combinational.
module dec3to8 (
  input  logic       en_i,
  input  logic [2:0] sel_i,
  output logic [7:0] dat_o
);

  assign dat_o = en_i ? (8'b1 << sel_i) : 8'b0;

endmodule

// File: rtl/proc_control_fsm.sv
// Multi-cycle fetch/execute control unit for the 16-bit bus processor.
// Strobes are combinational from state, IR and G_nz; Run sampled only at instruction boundaries.
module proc_control_fsm #(
  parameter int unsigned NREG   = 8,
  parameter int unsigned PC_IDX = 7,
  parameter int unsigned IR_W   = 9
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Run,
  input  logic [IR_W-1:0] IR,
  input  logic            G_nz,
  output logic            IRin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            Ain,
  output logic            Gin,
  output logic            Gout,
  output logic            DINout,
  output logic            AddSub,
  output logic            ADDRin,
  output logic            DOUTin,
  output logic            W_D,
  output logic            incr_pc,
  output logic            Done
);

  import proc_pkg::*;

  localparam logic [2:0] PC_SEL = 3'(PC_IDX);

  state_t state_q, state_d;

  logic [2:0] op, x_fld, y_fld;
  logic       rin_en, rout_en;
  logic [2:0] rout_idx;

  assign op    = IR[IR_W-1 -: 3];
  assign x_fld = IR[5:3];
  assign y_fld = IR[2:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = Run ? F_ADDR : IDLE;
      F_ADDR:  state_d = F_WAIT;
      F_WAIT:  state_d = F_LOAD;
      F_LOAD:  state_d = E1;
      E1:      state_d = is_short_op(op) ? (Run ? F_ADDR : IDLE) : E2;
      E2:      state_d = E3;
      E3:      state_d = Run ? F_ADDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Rin always targets X; Rout is steered to PC, X or Y depending on the step.
  always_comb begin
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_idx = y_fld;
    IRin     = 1'b0;
    Ain      = 1'b0;
    Gin      = 1'b0;
    Gout     = 1'b0;
    DINout   = 1'b0;
    AddSub   = 1'b0;
    ADDRin   = 1'b0;
    DOUTin   = 1'b0;
    W_D      = 1'b0;
    incr_pc  = 1'b0;
    Done     = 1'b0;
    unique case (state_q)
      F_ADDR: begin
        rout_en  = 1'b1;
        rout_idx = PC_SEL;
        ADDRin   = 1'b1;
        incr_pc  = 1'b1;
      end
      F_LOAD: begin
        DINout = 1'b1;
        IRin   = 1'b1;
      end
      E1: begin
        unique case (op)
          OP_MV: begin
            rout_en = 1'b1;
            rin_en  = 1'b1;
            Done    = 1'b1;
          end
          OP_MVI: begin
            rout_en  = 1'b1;
            rout_idx = PC_SEL;
            ADDRin   = 1'b1;
            incr_pc  = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rout_en  = 1'b1;
            rout_idx = x_fld;
            Ain      = 1'b1;
          end
          OP_LD, OP_ST: begin
            rout_en = 1'b1;
            ADDRin  = 1'b1;
          end
          OP_MVNZ: begin
            rout_en = G_nz;
            rin_en  = G_nz;
            Done    = 1'b1;
          end
          default: Done = 1'b1;
        endcase
      end
      E2: begin
        unique case (op)
          OP_ADD, OP_SUB: begin
            rout_en = 1'b1;
            Gin     = 1'b1;
            AddSub  = (op == OP_SUB);
          end
          OP_ST: begin
            rout_en  = 1'b1;
            rout_idx = x_fld;
            DOUTin   = 1'b1;
          end
          default: ;
        endcase
      end
      E3: begin
        Done = 1'b1;
        unique case (op)
          OP_MVI, OP_LD: begin
            DINout = 1'b1;
            rin_en = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            Gout   = 1'b1;
            rin_en = 1'b1;
          end
          OP_ST:   W_D = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  dec3to8 u_dec_rin (
    .en_i  (rin_en),
    .sel_i (x_fld),
    .dat_o (Rin)
  );

  dec3to8 u_dec_rout (
    .en_i  (rout_en),
    .sel_i (rout_idx),
    .dat_o (Rout)
  );

endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed per-cycle checks of the control strobes for each instruction class,
// including reset behaviour and bus-exclusivity invariants.
module tb_proc_control_fsm;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Run   = 1'b0;
  logic [8:0] IR    = 9'b0;
  logic       G_nz  = 1'b0;

  logic       IRin, Ain, Gin, Gout, DINout, AddSub, ADDRin, DOUTin, W_D, incr_pc, Done;
  logic [7:0] Rin, Rout;

  proc_control_fsm dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Run    (Run),
    .IR     (IR),
    .G_nz   (G_nz),
    .IRin   (IRin),
    .Rin    (Rin),
    .Rout   (Rout),
    .Ain    (Ain),
    .Gin    (Gin),
    .Gout   (Gout),
    .DINout (DINout),
    .AddSub (AddSub),
    .ADDRin (ADDRin),
    .DOUTin (DOUTin),
    .W_D    (W_D),
    .incr_pc(incr_pc),
    .Done   (Done)
  );

  always #5 Clock = ~Clock;

  // {IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, ADDRin, DOUTin, W_D, incr_pc, Done}
  logic [26:0] outs;
  assign outs = {IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, ADDRin, DOUTin, W_D, incr_pc, Done};

  localparam logic [26:0] DONE   = 27'd1 << 0;
  localparam logic [26:0] INCPC  = 27'd1 << 1;
  localparam logic [26:0] WD     = 27'd1 << 2;
  localparam logic [26:0] DOUTIN = 27'd1 << 3;
  localparam logic [26:0] ADDRIN = 27'd1 << 4;
  localparam logic [26:0] ADDSUB = 27'd1 << 5;
  localparam logic [26:0] DINOUT = 27'd1 << 6;
  localparam logic [26:0] GOUT   = 27'd1 << 7;
  localparam logic [26:0] GIN    = 27'd1 << 8;
  localparam logic [26:0] AIN    = 27'd1 << 9;
  localparam logic [26:0] IRIN   = 27'd1 << 26;

  function automatic logic [26:0] rout(input logic [7:0] v);
    return {9'b0, v, 10'b0};
  endfunction

  function automatic logic [26:0] rin(input logic [7:0] v);
    return {1'b0, v, 18'b0};
  endfunction

  localparam logic [26:0] FA = {9'b0, 8'h80, 10'b0} | ADDRIN | INCPC;
  localparam logic [26:0] FL = DINOUT | IRIN;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [26:0] got, input logic [26:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive inputs for one cycle, then check strobes and invariants.
  task automatic step(input string tag, input logic run, input logic [8:0] ir,
                      input logic gnz, input logic [26:0] exp);
    logic [26:0] inv;
    @(negedge Clock);
    Run  = run;
    IR   = ir;
    G_nz = gnz;
    #1;
    chk(tag, outs, exp);
    inv = {24'b0,
           ($countones({Rout, Gout, DINout}) <= 1),
           $onehot0(Rin),
           !(incr_pc && Rin[7])};
    chk({tag, "_inv"}, inv, 27'd7);
  endtask

  localparam logic [8:0] I_MV   = 9'b000_010_101;
  localparam logic [8:0] I_SUB  = 9'b011_001_011;
  localparam logic [8:0] I_ST   = 9'b101_100_000;
  localparam logic [8:0] I_MVNZ = 9'b110_111_110;
  localparam logic [8:0] I_MVI  = 9'b001_011_000;
  localparam logic [8:0] I_ADD  = 9'b010_011_011;
  localparam logic [8:0] I_NOP  = 9'b111_000_000;
  localparam logic [8:0] I_LD   = 9'b100_110_001;

  initial begin
    // Reset held, then idle with Run low.
    step("rst_hold", 1'b0, I_MV, 1'b0, 27'd0);
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) step("idle", 1'b0, I_MV, 1'b0, 27'd0);

    // mv R2,R5
    step("mv_idle", 1'b1, I_MV, 1'b0, 27'd0);
    step("mv_fa",   1'b1, I_MV, 1'b0, FA);
    step("mv_fw",   1'b1, I_MV, 1'b0, 27'd0);
    step("mv_fl",   1'b1, I_MV, 1'b0, FL);
    step("mv_e1",   1'b1, I_MV, 1'b0, rout(8'h20) | rin(8'h04) | DONE);

    // sub R1,R3 back to back
    step("sub_fa", 1'b1, I_SUB, 1'b0, FA);
    step("sub_fw", 1'b1, I_SUB, 1'b0, 27'd0);
    step("sub_fl", 1'b1, I_SUB, 1'b0, FL);
    step("sub_e1", 1'b1, I_SUB, 1'b0, rout(8'h02) | AIN);
    step("sub_e2", 1'b1, I_SUB, 1'b0, rout(8'h08) | GIN | ADDSUB);
    step("sub_e3", 1'b1, I_SUB, 1'b0, GOUT | rin(8'h02) | DONE);

    // st R4,[R0]
    step("st_fa", 1'b1, I_ST, 1'b0, FA);
    step("st_fw", 1'b1, I_ST, 1'b0, 27'd0);
    step("st_fl", 1'b1, I_ST, 1'b0, FL);
    step("st_e1", 1'b1, I_ST, 1'b0, rout(8'h01) | ADDRIN);
    step("st_e2", 1'b1, I_ST, 1'b0, rout(8'h10) | DOUTIN);
    step("st_e3", 1'b1, I_ST, 1'b0, WD | DONE);

    // mvnz R7,R6 with G zero, then nonzero
    step("mvnz0_fa", 1'b1, I_MVNZ, 1'b0, FA);
    step("mvnz0_fw", 1'b1, I_MVNZ, 1'b0, 27'd0);
    step("mvnz0_fl", 1'b1, I_MVNZ, 1'b0, FL);
    step("mvnz0_e1", 1'b1, I_MVNZ, 1'b0, DONE);
    step("mvnz1_fa", 1'b1, I_MVNZ, 1'b1, FA);
    step("mvnz1_fw", 1'b1, I_MVNZ, 1'b1, 27'd0);
    step("mvnz1_fl", 1'b1, I_MVNZ, 1'b1, FL);
    step("mvnz1_e1", 1'b1, I_MVNZ, 1'b1, rout(8'h40) | rin(8'h80) | DONE);

    // reserved opcode as NOP
    step("nop_fa", 1'b1, I_NOP, 1'b0, FA);
    step("nop_fw", 1'b1, I_NOP, 1'b0, 27'd0);
    step("nop_fl", 1'b1, I_NOP, 1'b0, FL);
    step("nop_e1", 1'b1, I_NOP, 1'b0, DONE);

    // ld R6,[R1]
    step("ld_fa", 1'b1, I_LD, 1'b0, FA);
    step("ld_fw", 1'b1, I_LD, 1'b0, 27'd0);
    step("ld_fl", 1'b1, I_LD, 1'b0, FL);
    step("ld_e1", 1'b1, I_LD, 1'b0, rout(8'h02) | ADDRIN);
    step("ld_e2", 1'b1, I_LD, 1'b0, 27'd0);
    step("ld_e3", 1'b1, I_LD, 1'b0, DINOUT | rin(8'h40) | DONE);

    // mvi R3 with Run dropped mid-instruction, then idle
    step("mvi_fa", 1'b1, I_MVI, 1'b0, FA);
    step("mvi_fw", 1'b1, I_MVI, 1'b0, 27'd0);
    step("mvi_fl", 1'b1, I_MVI, 1'b0, FL);
    step("mvi_e1", 1'b1, I_MVI, 1'b0, rout(8'h80) | ADDRIN | INCPC);
    step("mvi_e2", 1'b0, I_MVI, 1'b0, 27'd0);
    step("mvi_e3", 1'b0, I_MVI, 1'b0, DINOUT | rin(8'h08) | DONE);
    step("mvi_idle1", 1'b0, I_MVI, 1'b0, 27'd0);
    step("mvi_idle2", 1'b0, I_MVI, 1'b0, 27'd0);

    // add R3,R3, reset asserted during E2
    step("add_idle", 1'b1, I_ADD, 1'b0, 27'd0);
    step("add_fa",   1'b1, I_ADD, 1'b0, FA);
    step("add_fw",   1'b1, I_ADD, 1'b0, 27'd0);
    step("add_fl",   1'b1, I_ADD, 1'b0, FL);
    step("add_e1",   1'b1, I_ADD, 1'b0, rout(8'h08) | AIN);
    step("add_e2",   1'b1, I_ADD, 1'b0, rout(8'h08) | GIN);
    Reset = 1'b1;
    #1;
    chk("rst_async", outs, 27'd0);
    step("rst_mid", 1'b1, I_ADD, 1'b0, 27'd0);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("rst_rel_idle", outs, 27'd0);
    step("restart_fa", 1'b1, I_ADD, 1'b0, FA);
    step("restart_fw", 1'b0, I_ADD, 1'b0, 27'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
